// File: rtl/huff_bit_packer.sv
// Packs right-aligned variable-length codes MSB-first into BUS_WIDTH-bit words,
// with a single output holding register and a flush path that tags the trailing partial word.
module huff_bit_packer #(
  parameter int BUS_WIDTH    = 64,
  parameter int MAX_CODE_LEN = 16,
  localparam int LEN_W  = $clog2(MAX_CODE_LEN + 1),
  localparam int BITS_W = $clog2(BUS_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [MAX_CODE_LEN-1:0] code_in,
  input  logic [LEN_W-1:0]        len_in,
  input  logic                    flush,
  output logic                    busy,
  output logic [BUS_WIDTH-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic [BITS_W-1:0]       dout_bits,
  output logic [31:0]             total_bits
);

  localparam int ACC_W = BUS_WIDTH + MAX_CODE_LEN;
  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 dout_last_q, dout_last_d;
  logic [BITS_W-1:0]    dout_bits_q, dout_bits_d;
  logic [31:0]          total_q, total_d;

  logic                    busy_c;
  logic                    slot_free;
  logic                    full_word;
  logic [LEN_W-1:0]        len_clamp;
  logic [MAX_CODE_LEN-1:0] code_mask;
  logic [CNT_W-1:0]        shamt;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_bits_d  = dout_bits_q;
    total_d      = total_q;

    full_word = (cnt_q >= CNT_W'(BUS_WIDTH));
    busy_c    = full_word || (state_q == FLUSH);
    slot_free = !dout_valid_q || dout_ready;
    len_clamp = (len_in > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : len_in;
    code_mask = code_in & ~({MAX_CODE_LEN{1'b1}} << len_clamp);
    // New code lands directly below the cnt valid bits of the MSB-aligned accumulator.
    shamt     = CNT_W'(ACC_W) - cnt_q - CNT_W'(len_clamp);

    if (dout_valid_q && dout_ready)
      dout_valid_d = 1'b0;

    if (full_word && slot_free) begin
      dout_d       = acc_q[ACC_W-1 -: BUS_WIDTH];
      dout_valid_d = 1'b1;
      dout_last_d  = 1'b0;
      dout_bits_d  = BITS_W'(BUS_WIDTH);
      acc_d        = acc_q << BUS_WIDTH;
      cnt_d        = cnt_q - CNT_W'(BUS_WIDTH);
    end else if (state_q == FLUSH && slot_free) begin
      // Bits below cnt are always zero, so the top slice is already zero-padded.
      dout_d       = acc_q[ACC_W-1 -: BUS_WIDTH];
      dout_valid_d = 1'b1;
      dout_last_d  = 1'b1;
      dout_bits_d  = BITS_W'(cnt_q);
      acc_d        = '0;
      cnt_d        = '0;
      total_d      = '0;
      state_d      = RUN;
    end

    if (!busy_c) begin
      if (we) begin
        acc_d   = acc_q | (ACC_W'(code_mask) << shamt);
        cnt_d   = cnt_q + CNT_W'(len_clamp);
        total_d = total_q + 32'(len_clamp);
      end
      if (flush)
        state_d = FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_bits_q  <= '0;
      total_q      <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_bits_q  <= dout_bits_d;
      total_q      <= total_d;
    end
  end

  assign busy       = busy_c;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_bits  = dout_bits_q;
  assign total_bits = total_q;

endmodule

// File: tb/tb_huff_bit_packer.sv
// Bench for huff_bit_packer: directed scenarios plus randomized traffic scored
// against a bit-queue model of the packed stream.
module tb_huff_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [15:0] code_in = '0;
  logic [4:0]  len_in = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        dout_last;
  logic [6:0]  dout_bits;
  logic [31:0] total_bits;

  int checks = 0;
  int errors = 0;

  // Model: accepted code bits in stream order, and flush boundaries as bit offsets into that queue.
  bit          mbits[$];
  int          marks[$];
  logic [31:0] model_total = '0;

  huff_bit_packer #(.BUS_WIDTH(64), .MAX_CODE_LEN(16)) dut (
    .clk(clk), .rst(rst), .we(we), .code_in(code_in), .len_in(len_in),
    .flush(flush), .busy(busy), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .dout_bits(dout_bits),
    .total_bits(total_bits)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Observes the handshakes that will happen at the coming edge, scores transfers, then advances one cycle.
  task automatic step();
    int l, nb;
    bit el;
    logic [63:0] ew;
    if (rst) begin
      if (we && !busy) begin
        l = (len_in > 16) ? 16 : int'(len_in);
        for (int b = l - 1; b >= 0; b--) mbits.push_back(code_in[b]);
        model_total += 32'(l);
      end
      if (flush && !busy) begin
        marks.push_back(mbits.size());
        model_total = '0;
      end
      if (dout_valid && dout_ready) begin
        ew = '0;
        if (marks.size() > 0 && marks[0] < 64) begin
          nb = marks[0]; el = 1'b1; void'(marks.pop_front());
        end else begin
          nb = 64; el = 1'b0;
        end
        foreach (marks[i]) marks[i] -= nb;
        checks++;
        if (mbits.size() < nb) begin
          errors++;
          $display("FAIL xfer_underflow: word out with only %0d model bits, need %0d", mbits.size(), nb);
        end else begin
          for (int i = 0; i < nb; i++) ew[63-i] = mbits.pop_front();
          if (dout !== ew || dout_last !== el || dout_bits !== 7'(nb)) begin
            errors++;
            $display("FAIL xfer_word: got %h last=%0b bits=%0d, want %h last=%0b bits=%0d",
                     dout, dout_last, dout_bits, ew, el, nb);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] c, input int l);
    int n = 0;
    code_in = c; len_in = 5'(l); we = 1'b1;
    while (busy && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL write_wait: busy=%0b after %0d cycles, want 0", busy, n); end
    step();
    we = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    flush = 1'b1;
    while (busy && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL flush_wait: busy=%0b after %0d cycles, want 0", busy, n); end
    step();
    flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    we = 1'b0; flush = 1'b0; dout_ready = 1'b1;
    while ((mbits.size() > 0 || marks.size() > 0 || dout_valid) && n < 500) begin step(); n++; end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain: %0d bits %0d marks valid=%0b left, want none", mbits.size(), marks.size(), dout_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, dout, dout_valid, dout_last, dout_bits, total_bits} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b dout=%h v=%0b last=%0b bits=%0d total=%0d, want all 0",
               busy, dout, dout_valid, dout_last, dout_bits, total_bits);
    end
    #20 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_four_words();
    dout_ready = 1'b1;
    do_write(16'h0123, 16); do_write(16'h4567, 16);
    do_write(16'h89AB, 16); do_write(16'hCDEF, 16);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL four_busy_hi: busy=%0b want 1", busy); end
    step();
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b1 || dout !== 64'h0123456789ABCDEF ||
        dout_last !== 1'b0 || dout_bits !== 7'd64 || total_bits !== 32'd64) begin
      errors++;
      $display("FAIL four_word: busy=%0b v=%0b dout=%h last=%0b bits=%0d total=%0d, want 0 1 0123456789abcdef 0 64 64",
               busy, dout_valid, dout, dout_last, dout_bits, total_bits);
    end
    step();
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL four_consumed: v=%0b want 0", dout_valid); end
  endtask

  task automatic test_flush_short();
    dout_ready = 1'b1;
    do_write(16'h0005, 3);
    do_flush();
    step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'hA000000000000000 || dout_last !== 1'b1 ||
        dout_bits !== 7'd3 || total_bits !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_short: v=%0b dout=%h last=%0b bits=%0d total=%0d busy=%0b, want 1 a000000000000000 1 3 0 0",
               dout_valid, dout, dout_last, dout_bits, total_bits, busy);
    end
    step();
  endtask

  task automatic test_two_words();
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) do_write(16'h1FFF, 13);
    step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'hFFFFFFFFFFFFFFFF || dout_bits !== 7'd64 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL two_first: v=%0b dout=%h bits=%0d last=%0b, want 1 ffffffffffffffff 64 0",
               dout_valid, dout, dout_bits, dout_last);
    end
    do_flush();
    step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'h8000000000000000 || dout_bits !== 7'd1 || dout_last !== 1'b1) begin
      errors++;
      $display("FAIL two_second: v=%0b dout=%h bits=%0d last=%0b, want 1 8000000000000000 1 1",
               dout_valid, dout, dout_bits, dout_last);
    end
    step();
  endtask

  task automatic test_mask_clamp();
    dout_ready = 1'b1;
    do_write(16'hFFFF, 4);
    do_write(16'hFFFF, 0);
    do_write(16'h0001, 20);
    do_flush();
    step();
    checks++;
    if (dout !== 64'hF000100000000000 || dout_bits !== 7'd20 || dout_last !== 1'b1) begin
      errors++;
      $display("FAIL mask_clamp: dout=%h bits=%0d last=%0b, want f000100000000000 20 1", dout, dout_bits, dout_last);
    end
    step();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    bit ok, have = 0;
    logic [63:0] held = '0;
    dout_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      we = 1'b1; code_in = 16'(idx); len_in = 5'd16;
      ok = !busy;
      step();
      if (ok) idx++;
      if (dout_valid) begin
        if (!have) begin held = dout; have = 1; end
        else begin
          checks++;
          if (dout !== held) begin errors++; $display("FAIL bp_hold: dout=%h want %h", dout, held); end
        end
      end
    end
    we = 1'b0;
    checks++;
    if (idx != 8 || busy !== 1'b1 || dout_valid !== 1'b1 || dout !== 64'h0000000100020003) begin
      errors++;
      $display("FAIL bp_stall: accepted=%0d busy=%0b v=%0b dout=%h, want 8 1 1 0000000100020003",
               idx, busy, dout_valid, dout);
    end
    dout_ready = 1'b1;
    step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'h0004000500060007 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_second: v=%0b dout=%h busy=%0b, want 1 0004000500060007 0", dout_valid, dout, busy);
    end
    step();
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: v=%0b want 0", dout_valid); end
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_write(16'($urandom), 16);
    step();
    do_write(16'($urandom), 16); do_write(16'($urandom), 16); do_write(16'($urandom), 8);
    checks++;
    if (dout_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: v=%0b want 1", dout_valid); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, dout, dout_valid, dout_last, dout_bits, total_bits} !== '0) begin
      errors++;
      $display("FAIL rmid_async: busy=%0b dout=%h v=%0b last=%0b bits=%0d total=%0d, want all 0",
               busy, dout, dout_valid, dout_last, dout_bits, total_bits);
    end
    mbits.delete(); marks.delete(); model_total = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    dout_ready = 1'b1;
    do_flush();
    step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'h0 || dout_bits !== 7'd0 || dout_last !== 1'b1) begin
      errors++;
      $display("FAIL rmid_flush: v=%0b dout=%h bits=%0d last=%0b, want 1 0 0 1", dout_valid, dout, dout_bits, dout_last);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      we         = ($urandom_range(0, 3) != 0);
      code_in    = 16'($urandom);
      len_in     = 5'($urandom_range(0, 20));
      flush      = ($urandom_range(0, 29) == 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      step();
      if (!busy && marks.size() == 0) begin
        checks++;
        if (total_bits !== model_total) begin
          errors++;
          $display("FAIL rand_total: total_bits=%0d want %0d", total_bits, model_total);
        end
      end
    end
    we = 1'b0; flush = 1'b0;
    do_flush();
    drain();
    checks++;
    if (total_bits !== model_total || model_total !== 32'd0) begin
      errors++;
      $display("FAIL rand_end_total: total_bits=%0d want %0d", total_bits, model_total);
    end
  endtask

  initial begin
    test_reset();
    test_four_words();
    test_flush_short();
    test_two_words();
    test_mask_clamp();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
